// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial sequence detector with KMP-style progress tracking.
// Optional saturating match counter is built only when SEQ_DET_MATCH_CNT_EN is defined.
module mealy_seq_detector #(
  parameter int                 SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] SEQ     = 3'b011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       x,
  output logic                       y,
  output logic [$clog2(SEQ_LEN)-1:0] state_o,
  output logic [CNT_W-1:0]           match_count
);

  localparam int SW = $clog2(SEQ_LEN);
  localparam int NS = 1 << SW;

  typedef logic [SW-1:0] state_t;

  // Longest prefix of SEQ (at most max_k bits) that is a suffix of the first
  // s pattern bits followed by b. Pattern bit i in arrival order is SEQ[SEQ_LEN-1-i].
  function automatic int kmp_next(input int s, input logic b, input int max_k);
    int   best;
    int   idx;
    logic ok;
    logic tbit;
    best = 0;
    for (int k = 1; k <= SEQ_LEN; k++) begin
      if (k <= max_k && k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < SEQ_LEN; j++) begin
          if (j < k) begin
            idx  = s + 1 - k + j;
            tbit = (idx == s) ? b : SEQ[SEQ_LEN-1-idx];
            if (tbit != SEQ[SEQ_LEN-1-j]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
    $error("mealy_seq_detector: SEQ_LEN must be in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("mealy_seq_detector: CNT_W must be at least 1");
  end

  localparam int     OVL_INT    = kmp_next(SEQ_LEN - 1, SEQ[0], SEQ_LEN - 1);
  localparam state_t LAST       = state_t'(SEQ_LEN - 1);
  localparam state_t MATCH_NEXT = OVERLAP ? state_t'(OVL_INT) : '0;

  state_t nxt0 [NS];
  state_t nxt1 [NS];

  // Unreachable codes (SEQ_LEN not a power of two) fall back to state 0.
  for (genvar g = 0; g < NS; g++) begin : g_tbl
    if (g < SEQ_LEN) begin : g_live
      localparam int LIM = (g + 1 < SEQ_LEN - 1) ? g + 1 : SEQ_LEN - 1;
      localparam int N0  = kmp_next(g, 1'b0, LIM);
      localparam int N1  = kmp_next(g, 1'b1, LIM);
      assign nxt0[g] = state_t'(N0);
      assign nxt1[g] = state_t'(N1);
    end else begin : g_dead
      assign nxt0[g] = '0;
      assign nxt1[g] = '0;
    end
  end

  state_t state_q;
  state_t state_d;
  logic   hit;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= '0;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hit     = en && !clr && (state_q == LAST) && (x == SEQ[0]);
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      if (hit)    state_d = MATCH_NEXT;
      else if (x) state_d = nxt1[state_q];
      else        state_d = nxt0[state_q];
    end
  end

  assign y       = reset_n & hit;
  assign state_o = state_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                cnt_q <= '0;
    else if (clr)                cnt_q <= '0;
    else if (y && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector: several parameterisations share one
// input stream; each test checks the instance it targets against hand values.
module tb_mealy_seq_detector;

`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, en, clr, x;

  logic       y_def, y_ov1, y_ov0, y_ones, y_sat;
  logic [1:0] st_def, st_ov1, st_ov0, st_ones, st_sat;
  logic [7:0] cnt_def, cnt_ov1, cnt_ov0, cnt_ones;
  logic [1:0] cnt_sat;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mealy_seq_detector u_def (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
    .y(y_def), .state_o(st_def), .match_count(cnt_def)
  );

  mealy_seq_detector #(.SEQ_LEN(4), .SEQ(4'b1010), .OVERLAP(1'b1)) u_ov1 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
    .y(y_ov1), .state_o(st_ov1), .match_count(cnt_ov1)
  );

  mealy_seq_detector #(.SEQ_LEN(4), .SEQ(4'b1010), .OVERLAP(1'b0)) u_ov0 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
    .y(y_ov0), .state_o(st_ov0), .match_count(cnt_ov0)
  );

  mealy_seq_detector #(.SEQ_LEN(3), .SEQ(3'b111), .OVERLAP(1'b1)) u_ones (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
    .y(y_ones), .state_o(st_ones), .match_count(cnt_ones)
  );

  mealy_seq_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
    .y(y_sat), .state_o(st_sat), .match_count(cnt_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one bit mid-cycle; y and state_o are then stable until the next rising edge.
  task automatic cyc(input logic xv, input logic ev, input logic cv, input logic rv);
    @(negedge clk);
    x = xv; en = ev; clr = cv; reset_n = rv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int xs[6];
    int es[6];
    int ey[6];
    int ey2[6];
    int es1[6];
    int es2[6];

    reset_n = 1'b0; en = 1'b0; clr = 1'b0; x = 1'b0;

    // Reset: outputs zero, y gated even with a would-be matching input.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_y_def", y_def, 0);
    check("rst_y_ones", y_ones, 0);
    check("rst_st_def", st_def, 0);
    check("rst_st_ov1", st_ov1, 0);
    check("rst_st_ov0", st_ov0, 0);
    check("rst_st_ones", st_ones, 0);
    check("rst_st_sat", st_sat, 0);
    check("rst_cnt_def", cnt_def, 0);
    check("rst_cnt_ov1", cnt_ov1, 0);
    check("rst_cnt_ov0", cnt_ov0, 0);
    check("rst_cnt_ones", cnt_ones, 0);
    check("rst_cnt_sat", cnt_sat, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 1: "011" on 0,1,1,0,1,1
    xs  = '{0, 1, 1, 0, 1, 1};
    ey  = '{0, 0, 1, 0, 0, 1};
    es1 = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      cyc(xs[i][0], 1'b1, 1'b0, 1'b1);
      check($sformatf("t1_y[%0d]", i), y_def, ey[i]);
      check($sformatf("t1_st[%0d]", i), st_def, es1[i]);
    end
    tick();
    check("t1_cnt", cnt_def, CNT_ON ? 2 : 0);
    check("t1_st_end", st_def, 0);

    // Test 2: "1010" overlap vs non-overlap on 1,0,1,0,1,0
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    xs  = '{1, 0, 1, 0, 1, 0};
    ey  = '{0, 0, 0, 1, 0, 1};
    ey2 = '{0, 0, 0, 1, 0, 0};
    es1 = '{0, 1, 2, 3, 2, 3};
    es2 = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      cyc(xs[i][0], 1'b1, 1'b0, 1'b1);
      check($sformatf("t2_y_ov1[%0d]", i), y_ov1, ey[i]);
      check($sformatf("t2_y_ov0[%0d]", i), y_ov0, ey2[i]);
      check($sformatf("t2_st_ov1[%0d]", i), st_ov1, es1[i]);
      check($sformatf("t2_st_ov0[%0d]", i), st_ov0, es2[i]);
    end

    // Test 3: enable gap does not break a partial match
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    xs  = '{0, 1, 1, 0, 1, 1};
    es  = '{1, 1, 0, 0, 0, 1};
    ey  = '{0, 0, 0, 0, 0, 1};
    es1 = '{0, 1, 2, 2, 2, 2};
    for (int i = 0; i < 6; i++) begin
      cyc(xs[i][0], es[i][0], 1'b0, 1'b1);
      check($sformatf("t3_y[%0d]", i), y_def, ey[i]);
      check($sformatf("t3_st[%0d]", i), st_def, es1[i]);
    end
    tick();
    check("t3_cnt", cnt_def, CNT_ON ? 1 : 0);

    // Test 4: reset mid-pattern, then clr mid-pattern
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check($sformatf("t4_y0[%0d]", r), y_def, 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("t4_y1[%0d]", r), y_def, 0);
      if (r == 0) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      else        cyc(1'b1, 1'b1, 1'b1, 1'b1);
      check($sformatf("t4_y_abort[%0d]", r), y_def, 0);
      check($sformatf("t4_st_pre[%0d]", r), st_def, 2);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("t4_st_post[%0d]", r), st_def, 0);
      check($sformatf("t4_y_last[%0d]", r), y_def, 0);
      check($sformatf("t4_cnt[%0d]", r), cnt_def, 0);
      tick();
      check($sformatf("t4_st_end[%0d]", r), st_def, 0);
    end

    // Test 5: counter saturation with CNT_W=2, then clr
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check($sformatf("t5_ya[%0d]", k), y_sat, 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("t5_yb[%0d]", k), y_sat, 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("t5_yc[%0d]", k), y_sat, 1);
      tick();
      check($sformatf("t5_cnt[%0d]", k), cnt_sat, CNT_ON ? ((k > 3) ? 3 : k) : 0);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("t5_y_clr", y_sat, 0);
    tick();
    check("t5_cnt_clr", cnt_sat, 0);

    // Test 6: all-ones pattern with overlap keeps firing
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    ey  = '{0, 0, 1, 1, 1, 0};
    es1 = '{0, 1, 2, 2, 2, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("t6_y[%0d]", i), y_ones, ey[i]);
      check($sformatf("t6_st[%0d]", i), st_ones, es1[i]);
    end
    tick();
    check("t6_st_end", st_ones, 2);
    check("t6_cnt", cnt_ones, CNT_ON ? 3 : 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
